// File: rtl/div_iq_pkg.sv
// Shared widths and the issue-queue entry record for the divider issue queue.
// The optional flush input is enabled by defining DIV_ISSUE_QUEUE_FLUSH_EN.
package div_iq_pkg;

    localparam int IQ_DATA_W = 32;
    localparam int IQ_TAG_W  = 6;

    typedef struct packed {
        logic                 valid;
        logic                 rs_ready;
        logic [IQ_TAG_W-1:0]  rs_tag;
        logic [IQ_DATA_W-1:0] rs_data;
        logic                 rt_ready;
        logic [IQ_TAG_W-1:0]  rt_tag;
        logic [IQ_DATA_W-1:0] rt_data;
        logic [IQ_TAG_W-1:0]  rdtag;
    } iq_entry_t;

endpackage

// File: rtl/div_issue_queue_if.sv
// Dispatch, CDB snoop and divider issue signals of the divider issue queue.
// master = the queue itself, slave = the surrounding pipeline / divider.
interface div_issue_queue_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
);
    logic              dispatch_en;
    logic [DATA_W-1:0] dispatch_rsdata;
    logic              dispatch_rsready;
    logic [TAG_W-1:0]  dispatch_rstag;
    logic [DATA_W-1:0] dispatch_rtdata;
    logic              dispatch_rtready;
    logic [TAG_W-1:0]  dispatch_rttag;
    logic [TAG_W-1:0]  dispatch_rdtag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              issuediv_busy;
    logic              issuediv_enable;
    logic [DATA_W-1:0] issuediv_rsdata;
    logic [DATA_W-1:0] issuediv_rtdata;
    logic [TAG_W-1:0]  issuediv_rdtag;
    logic              iq_full;
    logic              iq_empty;

    modport master (
        input  dispatch_en, dispatch_rsdata, dispatch_rsready, dispatch_rstag,
        input  dispatch_rtdata, dispatch_rtready, dispatch_rttag, dispatch_rdtag,
        input  cdb_valid, cdb_tag, cdb_data, issuediv_busy,
        output issuediv_enable, issuediv_rsdata, issuediv_rtdata, issuediv_rdtag,
        output iq_full, iq_empty
    );

    modport slave (
        output dispatch_en, dispatch_rsdata, dispatch_rsready, dispatch_rstag,
        output dispatch_rtdata, dispatch_rtready, dispatch_rttag, dispatch_rdtag,
        output cdb_valid, cdb_tag, cdb_data, issuediv_busy,
        input  issuediv_enable, issuediv_rsdata, issuediv_rtdata, issuediv_rdtag,
        input  iq_full, iq_empty
    );
endinterface

// File: rtl/div_iq_age_select.sv
// Age matrix for the divider issue queue: row i holds the entries older than i,
// and the oldest ready entry is the ready one with no older ready entry.
module div_iq_age_select #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     alloc_en,
    input  logic [$clog2(DEPTH)-1:0] alloc_idx,
    input  logic [DEPTH-1:0]         valid_vec,
    input  logic [DEPTH-1:0]         ready_vec,
    output logic                     sel_valid,
    output logic [$clog2(DEPTH)-1:0] sel_idx
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];
    logic [DEPTH-1:0] sel_onehot;

    // Clearing column alloc_idx drops stale "older than" bits left by the previous occupant.
    always_comb begin
        age_d = age_q;
        if (clear) begin
            for (int r = 0; r < DEPTH; r++) age_d[r] = '0;
        end else if (alloc_en) begin
            for (int r = 0; r < DEPTH; r++) age_d[r][alloc_idx] = 1'b0;
            age_d[alloc_idx] = valid_vec;
        end
    end

    always_comb begin
        sel_onehot = '0;
        sel_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel_onehot[i] = ready_vec[i] && ((age_q[i] & ready_vec) == '0);
            if (sel_onehot[i]) sel_idx = IDX_W'(i);
        end
        sel_valid = |sel_onehot;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) age_q[r] <= '0;
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/div_issue_queue.sv
// Divider issue queue: buffers dispatched divides, snoops the CDB for operands
// and issues the oldest ready one. Define DIV_ISSUE_QUEUE_FLUSH_EN for a flush input.
module div_issue_queue
    import div_iq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = IQ_DATA_W,
    parameter int TAG_W  = IQ_TAG_W
) (
    input  logic clk,
    input  logic reset,
`ifdef DIV_ISSUE_QUEUE_FLUSH_EN
    input  logic flush,
`endif
    div_issue_queue_if.master iq
);
    localparam int IDX_W = $clog2(DEPTH);

    iq_entry_t         entries_q [DEPTH];
    iq_entry_t         entries_d [DEPTH];
    logic              issue_en_q, issue_en_d;
    logic [DATA_W-1:0] issue_rsdata_q, issue_rsdata_d;
    logic [DATA_W-1:0] issue_rtdata_q, issue_rtdata_d;
    logic [TAG_W-1:0]  issue_rdtag_q, issue_rdtag_d;

    logic [DEPTH-1:0]  valid_vec, ready_vec;
    logic              free_found;
    logic [IDX_W-1:0]  free_idx;
    logic              sel_valid;
    logic [IDX_W-1:0]  sel_idx;
    logic              flush_now, dispatch_go, issue_go;
    logic              rs_bypass, rt_bypass;

`ifdef DIV_ISSUE_QUEUE_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    // Downward scan so the lowest-index free slot wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = entries_q[i].valid;
            ready_vec[i] = entries_q[i].valid && entries_q[i].rs_ready && entries_q[i].rt_ready;
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign dispatch_go = iq.dispatch_en && free_found && !flush_now;
    assign issue_go    = !iq.issuediv_busy && sel_valid && !issue_en_q && !flush_now;
    assign rs_bypass   = !iq.dispatch_rsready && iq.cdb_valid && (iq.cdb_tag == iq.dispatch_rstag);
    assign rt_bypass   = !iq.dispatch_rtready && iq.cdb_valid && (iq.cdb_tag == iq.dispatch_rttag);

    div_iq_age_select #(.DEPTH(DEPTH)) u_age (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush_now),
        .alloc_en  (dispatch_go),
        .alloc_idx (free_idx),
        .valid_vec (valid_vec),
        .ready_vec (ready_vec),
        .sel_valid (sel_valid),
        .sel_idx   (sel_idx)
    );

    always_comb begin
        entries_d = entries_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries_q[i].valid && iq.cdb_valid) begin
                if (!entries_q[i].rs_ready && entries_q[i].rs_tag == iq.cdb_tag) begin
                    entries_d[i].rs_ready = 1'b1;
                    entries_d[i].rs_data  = iq.cdb_data;
                end
                if (!entries_q[i].rt_ready && entries_q[i].rt_tag == iq.cdb_tag) begin
                    entries_d[i].rt_ready = 1'b1;
                    entries_d[i].rt_data  = iq.cdb_data;
                end
            end
        end
        if (issue_go) entries_d[sel_idx].valid = 1'b0;
        if (dispatch_go) begin
            entries_d[free_idx].valid    = 1'b1;
            entries_d[free_idx].rs_ready = iq.dispatch_rsready || rs_bypass;
            entries_d[free_idx].rs_tag   = iq.dispatch_rstag;
            entries_d[free_idx].rs_data  = rs_bypass ? iq.cdb_data : iq.dispatch_rsdata;
            entries_d[free_idx].rt_ready = iq.dispatch_rtready || rt_bypass;
            entries_d[free_idx].rt_tag   = iq.dispatch_rttag;
            entries_d[free_idx].rt_data  = rt_bypass ? iq.cdb_data : iq.dispatch_rtdata;
            entries_d[free_idx].rdtag    = iq.dispatch_rdtag;
        end
        if (flush_now) begin
            for (int i = 0; i < DEPTH; i++) entries_d[i].valid = 1'b0;
        end
    end

    always_comb begin
        issue_en_d     = issue_go;
        issue_rsdata_d = issue_rsdata_q;
        issue_rtdata_d = issue_rtdata_q;
        issue_rdtag_d  = issue_rdtag_q;
        if (issue_go) begin
            issue_rsdata_d = entries_q[sel_idx].rs_data;
            issue_rtdata_d = entries_q[sel_idx].rt_data;
            issue_rdtag_d  = entries_q[sel_idx].rdtag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            issue_en_q     <= 1'b0;
            issue_rsdata_q <= '0;
            issue_rtdata_q <= '0;
            issue_rdtag_q  <= '0;
        end else begin
            entries_q      <= entries_d;
            issue_en_q     <= issue_en_d;
            issue_rsdata_q <= issue_rsdata_d;
            issue_rtdata_q <= issue_rtdata_d;
            issue_rdtag_q  <= issue_rdtag_d;
        end
    end

    assign iq.issuediv_enable = issue_en_q;
    assign iq.issuediv_rsdata = issue_rsdata_q;
    assign iq.issuediv_rtdata = issue_rtdata_q;
    assign iq.issuediv_rdtag  = issue_rdtag_q;
    assign iq.iq_full         = &valid_vec;
    assign iq.iq_empty        = ~|valid_vec;

endmodule

// File: tb/tb_div_issue_queue.sv
// Self-checking bench for div_issue_queue: directed scenarios plus random traffic
// compared against a sequence-number based reference model.
module tb_div_issue_queue;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    int   tests;
    int   failed;

    div_issue_queue_if #(.DATA_W(32), .TAG_W(6)) iq_if ();

`ifdef DIV_ISSUE_QUEUE_FLUSH_EN
    logic flush;
    initial flush = 1'b0;
    div_issue_queue #(.DEPTH(DEPTH), .DATA_W(32), .TAG_W(6)) dut (
        .clk(clk), .reset(reset), .flush(flush), .iq(iq_if));
`else
    div_issue_queue #(.DEPTH(DEPTH), .DATA_W(32), .TAG_W(6)) dut (
        .clk(clk), .reset(reset), .iq(iq_if));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: entries age-ordered by a dispatch sequence number.
    logic        m_valid [DEPTH];
    logic        m_rsr   [DEPTH];
    logic [5:0]  m_rstag [DEPTH];
    logic [31:0] m_rsd   [DEPTH];
    logic        m_rtr   [DEPTH];
    logic [5:0]  m_rttag [DEPTH];
    logic [31:0] m_rtd   [DEPTH];
    logic [5:0]  m_rd    [DEPTH];
    int unsigned m_age   [DEPTH];
    int unsigned m_seq;
    logic        exp_en;
    logic [31:0] exp_rs, exp_rt;
    logic [5:0]  exp_rd;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        if (observed !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        exp_en = 1'b0; exp_rs = '0; exp_rt = '0; exp_rd = '0;
    endtask

    function automatic int modelCount();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) if (m_valid[i]) c++;
        return c;
    endfunction

    task automatic modelStep();
        int   pick = -1;
        int   slot = -1;
        logic iss;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && m_rsr[i] && m_rtr[i] && (pick < 0 || m_age[i] < m_age[pick])) pick = i;
            if (!m_valid[i] && slot < 0) slot = i;
        end
        iss = !iq_if.issuediv_busy && (pick >= 0) && !exp_en;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && iq_if.cdb_valid) begin
                if (!m_rsr[i] && m_rstag[i] == iq_if.cdb_tag) begin m_rsr[i] = 1'b1; m_rsd[i] = iq_if.cdb_data; end
                if (!m_rtr[i] && m_rttag[i] == iq_if.cdb_tag) begin m_rtr[i] = 1'b1; m_rtd[i] = iq_if.cdb_data; end
            end
        end
        exp_en = iss;
        if (iss) begin
            exp_rs = m_rsd[pick]; exp_rt = m_rtd[pick]; exp_rd = m_rd[pick];
            m_valid[pick] = 1'b0;
        end
        if (iq_if.dispatch_en && slot >= 0) begin
            m_valid[slot] = 1'b1;
            m_age[slot]   = m_seq++;
            m_rstag[slot] = iq_if.dispatch_rstag;
            m_rttag[slot] = iq_if.dispatch_rttag;
            m_rd[slot]    = iq_if.dispatch_rdtag;
            m_rsr[slot]   = iq_if.dispatch_rsready;
            m_rsd[slot]   = iq_if.dispatch_rsdata;
            m_rtr[slot]   = iq_if.dispatch_rtready;
            m_rtd[slot]   = iq_if.dispatch_rtdata;
            if (!m_rsr[slot] && iq_if.cdb_valid && iq_if.cdb_tag == m_rstag[slot]) begin
                m_rsr[slot] = 1'b1; m_rsd[slot] = iq_if.cdb_data;
            end
            if (!m_rtr[slot] && iq_if.cdb_valid && iq_if.cdb_tag == m_rttag[slot]) begin
                m_rtr[slot] = 1'b1; m_rtd[slot] = iq_if.cdb_data;
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("enable", 32'(iq_if.issuediv_enable), 32'(exp_en));
        checkOutput("rsdata", iq_if.issuediv_rsdata, exp_rs);
        checkOutput("rtdata", iq_if.issuediv_rtdata, exp_rt);
        checkOutput("rdtag",  32'(iq_if.issuediv_rdtag), 32'(exp_rd));
        checkOutput("full",   32'(iq_if.iq_full),  32'(modelCount() == DEPTH));
        checkOutput("empty",  32'(iq_if.iq_empty), 32'(modelCount() == 0));
    endtask

    task automatic applyStimulus(input logic den, input logic [31:0] rsd, input logic rsr, input logic [5:0] rstg,
                                 input logic [31:0] rtd, input logic rtr, input logic [5:0] rttg, input logic [5:0] rd,
                                 input logic cv, input logic [5:0] ct, input logic [31:0] cd, input logic busy);
        iq_if.dispatch_en = den;  iq_if.dispatch_rsdata = rsd; iq_if.dispatch_rsready = rsr;
        iq_if.dispatch_rstag = rstg; iq_if.dispatch_rtdata = rtd; iq_if.dispatch_rtready = rtr;
        iq_if.dispatch_rttag = rttg; iq_if.dispatch_rdtag = rd;
        iq_if.cdb_valid = cv; iq_if.cdb_tag = ct; iq_if.cdb_data = cd; iq_if.issuediv_busy = busy;
        modelStep();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic idle(input logic busy);
        applyStimulus(1'b0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 32'd0, busy);
    endtask

    task automatic cdbOnly(input logic [5:0] ct, input logic [31:0] cd);
        applyStimulus(1'b0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 6'd0, 1'b1, ct, cd, 1'b0);
    endtask

    initial begin
        tests = 0; failed = 0; m_seq = 0;
        modelReset();
        reset = 1'b1;
        iq_if.dispatch_en = 1'b0; iq_if.dispatch_rsdata = '0; iq_if.dispatch_rsready = 1'b0;
        iq_if.dispatch_rstag = '0; iq_if.dispatch_rtdata = '0; iq_if.dispatch_rtready = 1'b0;
        iq_if.dispatch_rttag = '0; iq_if.dispatch_rdtag = '0;
        iq_if.cdb_valid = 1'b0; iq_if.cdb_tag = '0; iq_if.cdb_data = '0; iq_if.issuediv_busy = 1'b0;
        repeat (2) @(negedge clk);
        checkAll();
        reset = 1'b0;

        // Both operands ready at dispatch.
        applyStimulus(1'b1, 32'd100, 1'b1, 6'd0, 32'd7, 1'b1, 6'd0, 6'd5, 1'b0, 6'd0, 32'd0, 1'b0);
        idle(1'b0);
        checkOutput("t1_rs", iq_if.issuediv_rsdata, 32'd100);
        checkOutput("t1_rd", 32'(iq_if.issuediv_rdtag), 32'd5);
        checkOutput("t1_empty", 32'(iq_if.iq_empty), 32'd1);

        // rt waits for CDB tag 12.
        applyStimulus(1'b1, 32'd20, 1'b1, 6'd0, 32'd0, 1'b0, 6'd12, 6'd6, 1'b0, 6'd0, 32'd0, 1'b0);
        idle(1'b0);
        cdbOnly(6'd12, 32'd3);
        idle(1'b0);
        checkOutput("t2_en", 32'(iq_if.issuediv_enable), 32'd1);
        checkOutput("t2_rt", iq_if.issuediv_rtdata, 32'd3);

        // Dispatch-cycle CDB bypass.
        applyStimulus(1'b1, 32'd0, 1'b0, 6'd9, 32'd2, 1'b1, 6'd0, 6'd7, 1'b1, 6'd9, 32'd42, 1'b0);
        idle(1'b0);
        checkOutput("t3_rs", iq_if.issuediv_rsdata, 32'd42);

        // Fill while busy, overflow dispatch ignored, then drain in age order.
        for (int k = 1; k <= 5; k++)
            applyStimulus(1'b1, 32'(k * 10), 1'b1, 6'd0, 32'(k), 1'b1, 6'd0, 6'(k), 1'b0, 6'd0, 32'd0, 1'b1);
        checkOutput("t4_full", 32'(iq_if.iq_full), 32'd1);
        repeat (9) idle(1'b0);

        // Younger ready entry overtakes older waiting entry.
        applyStimulus(1'b1, 32'd0, 1'b0, 6'd20, 32'd4, 1'b1, 6'd0, 6'd10, 1'b0, 6'd0, 32'd0, 1'b0);
        applyStimulus(1'b1, 32'd55, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 6'd11, 1'b0, 6'd0, 32'd0, 1'b0);
        idle(1'b0);
        checkOutput("t5_first", 32'(iq_if.issuediv_rdtag), 32'd11);
        cdbOnly(6'd20, 32'd99);
        idle(1'b0);
        checkOutput("t5_second", 32'(iq_if.issuediv_rdtag), 32'd10);

        // Reset while a strobe is pending and another entry waits.
        applyStimulus(1'b1, 32'd0, 1'b0, 6'd30, 32'd1, 1'b1, 6'd0, 6'd12, 1'b0, 6'd0, 32'd0, 1'b0);
        applyStimulus(1'b1, 32'd8, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0, 6'd13, 1'b0, 6'd0, 32'd0, 1'b0);
        idle(1'b0);
        checkOutput("t6_pending", 32'(iq_if.issuediv_enable), 32'd1);
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("t6_en", 32'(iq_if.issuediv_enable), 32'd0);
        checkOutput("t6_rs", iq_if.issuediv_rsdata, 32'd0);
        checkOutput("t6_rd", 32'(iq_if.issuediv_rdtag), 32'd0);
        checkOutput("t6_empty", 32'(iq_if.iq_empty), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Random traffic with a small tag space so CDB hits are frequent.
        for (int n = 0; n < 500; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                          $urandom(), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 63)),
                          1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom(),
                          1'($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
